// File: rtl/coproc_sequencer_if.sv
// coproc_sequencer_if: instruction issue handshake between the sequencer and
// the matrix coprocessor.
// Ports: cp_instr / cp_start (sequencer -> coprocessor),
//        cp_done / cp_overflow (coprocessor -> sequencer).
interface coproc_sequencer_if #(
   parameter int IW = 22
);
   logic [IW-1:0] cp_instr;
   logic          cp_start;
   logic          cp_done;
   logic          cp_overflow;

   modport master (
      output cp_instr,
      output cp_start,
      input  cp_done,
      input  cp_overflow
   );

   modport slave (
      input  cp_instr,
      input  cp_start,
      output cp_done,
      output cp_overflow
   );
endinterface

// File: rtl/coproc_sequencer.sv
// coproc_sequencer: stores a short coprocessor program and issues it one
// instruction at a time, free-running (start) or single-step (step).
// Latency: start -> cp_start two cycles later; cp_done -> next cp_start two cycles later.
// Backpressure: one instruction outstanding at a time; the next is not issued until cp_done.
// Ports: clk, rst_n (async, active-low); wr_en/wr_data/clr program loading (IDLE only);
//        start/step/abort control; cp (master) coprocessor handshake;
//        pc, count, full, busy, done, err_ovf status.
// Option: SEQ_OVF_HALT_EN - halt in FIN with err_ovf when cp_done reports overflow.
module coproc_sequencer #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int IW    = 22
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_data,
   input  logic              clr,
   input  logic              start,
   input  logic              step,
   input  logic              abort,
   coproc_sequencer_if.master cp,
   output logic [AW-1:0]     pc,
   output logic [AW:0]       count,
   output logic              full,
   output logic              busy,
   output logic              done,
   output logic              err_ovf
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, PAUSE, FIN} state_t;

   state_t        state;
   logic          run;
   logic          err_q;
   logic [IW-1:0] mem [DEPTH];
   logic          wr_ok;
   logic          last;
   logic          ovf_hit;

`ifdef SEQ_OVF_HALT_EN
   assign ovf_hit = cp.cp_overflow;
`else
   // Overflow never halts the program, so err_q stays at its reset value.
   logic unused_ovf;
   assign unused_ovf = cp.cp_overflow;
   assign ovf_hit    = 1'b0;
`endif

   assign full    = (count == (AW+1)'(DEPTH));
   assign err_ovf = err_q;
   // clr beats a simultaneous write; abort beats everything.
   assign wr_ok   = (state == IDLE) && wr_en && !clr && !full && !abort;
   // Checked before the increment, so pc never wraps.
   assign last    = ({1'b0, pc} == count - 1'b1);

   // Program store: no reset, written at the current fill level.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[count[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      state_t nxt;
      if (!rst_n) begin
         state       <= IDLE;
         run         <= 1'b0;
         err_q       <= 1'b0;
         pc          <= '0;
         count       <= '0;
         cp.cp_instr <= '0;
         cp.cp_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         nxt         = state;
         cp.cp_start <= 1'b0;
         if (abort) begin
            nxt   = IDLE;
            pc    <= '0;
            err_q <= 1'b0;
         end else begin
            case (state)
               IDLE, FIN: begin
                  if (state == IDLE && clr)
                     count <= '0;
                  else if (wr_ok)
                     count <= count + 1'b1;
                  if ((start || step) && count != '0) begin
                     nxt   = FETCH;
                     pc    <= '0;
                     run   <= start;
                     err_q <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (start || step) begin
                     nxt   = FETCH;
                     err_q <= 1'b0;
                     if (start)
                        run <= 1'b1;
                  end
               end
               FETCH: begin
                  // The memory read lands straight in the output register.
                  cp.cp_instr <= mem[pc];
                  cp.cp_start <= 1'b1;
                  nxt         = ISSUE;
               end
               ISSUE: nxt = WAIT;
               WAIT: begin
                  if (cp.cp_done) begin
                     if (ovf_hit) begin
                        nxt   = FIN;
                        err_q <= 1'b1;
                     end else if (last) begin
                        nxt = FIN;
                     end else begin
                        pc  <= pc + 1'b1;
                        nxt = run ? FETCH : PAUSE;
                     end
                  end
               end
               default: nxt = IDLE;
            endcase
         end
         state <= nxt;
         busy  <= (nxt == FETCH) || (nxt == ISSUE) || (nxt == WAIT);
         done  <= (nxt == FIN);
      end
   end

endmodule
